encoder: RTL and testbench
==========================

# encoder

Keypad front end of the microwave controller. It converts a 10-key one-hot keypad into a 4-bit BCD digit with a one-cycle `load` strobe for the time-entry register. Multi-key presses and bounce are rejected. While the oven is running (`enable`=1), keypad entry is locked out and the block instead generates the 1 Hz countdown clock `pgt_1hz`.

## Interface
- `CLK_HZ`, 100: clock frequency in Hz; the 1 Hz divider ratio.
- `DEBOUNCE_CYCLES`, 3: consecutive stable samples required before a key is accepted (≥1).
- `clk` input 1: system clock, rising edge; 100 Hz in the system.
- `reset` input 1: synchronous, active-high.
- `keypad` input 10: one-hot key lines; bit *n* = digit *n* (bit0 = "0", bit9 = "9"), active-high.
- `enable` input 1: 1 = oven running (keypad locked, divider runs); 0 = entry mode.
- `D` output 4: BCD code of the last accepted key, 0–9.
- `load` output 1: single-cycle strobe; `D` is valid in the same cycle.
- `pgt_1hz` output 1: 1 Hz square wave while `enable`=1; rising edge = one countdown tick.

## Operation
- Input stage: `keypad` is registered into `kp_q` every cycle.
- Validity: `kp_q` is valid when exactly one bit is set. All-zero means idle. Any other value is invalid and is treated like idle for acceptance, but does not re-arm.
- Debounce: the counter increments while `kp_q` is valid and equal to the previous sample. It clears on any change or on an invalid/idle value.
- Acceptance: when the count reaches `DEBOUNCE_CYCLES` and the block is armed and `enable`=0:
  - `D` takes the encoded value.
  - `load` pulses high for 1 cycle.
  - The block disarms.
- Re-arm: the block re-arms only after `kp_q` is seen all-zero for one cycle. A held key produces exactly one `load`.
- When `enable`=1: `load` is held at 0, acceptance is inhibited, and `D` holds its value.
- Divider, `enable`=1: `cnt` steps 0..`CLK_HZ`-1 and wraps. `pgt_1hz` is registered as (`cnt` < `CLK_HZ`/2).
- Divider, `enable`=0: `cnt`=0 and `pgt_1hz`=0.

## Timing
- Reset values: `D`=0, `load`=0, `pgt_1hz`=0, `cnt`=0, debounce count=0, armed=1, `kp_q`=0.
- Reset has priority over all other behaviour. A reset asserted mid-press requires the key to be released before it can be accepted again.
- Key latency:
  - `keypad` is sampled into `kp_q` at edge E0.
  - `load` is high in the cycle following edge E0+`DEBOUNCE_CYCLES`.
  - With the defaults, that is 4 edges after the key is applied.
- Key released before `DEBOUNCE_CYCLES` stable samples: no `load`, `D` unchanged.
- `enable` rising while a key is stable and pending: no `load`. The block stays armed only if it had not already accepted that key.
- Divider start: on the first edge with `enable`=1, `pgt_1hz` goes 1. It stays high for `CLK_HZ`/2 cycles and low for `CLK_HZ` - `CLK_HZ`/2 cycles, for a period of `CLK_HZ` cycles (1 s).
- `enable` falling: `pgt_1hz` is 0 on the next edge and the phase restarts on the next enable.
- `load` and `pgt_1hz` are never simultaneously active due to the same key.

## Structure
- Shared microwave package holds:
  - `KEYS`=10 and `BCD_W`=4.
  - The one-hot→BCD encode function, also reused by the display decoder.
- Natural sub-module `pulse_1hz_gen`: the divider with `enable`, parameter `CLK_HZ`.
- Debounce, validity check and encode logic stay in `encoder`.

## Test plan
- Reset, then `enable`=0 with idle keypad → `D`=0, `load`=0 and `pgt_1hz`=0 throughout.
- `keypad`=10'b1000000000 held 10 cycles, then released:
  - Exactly one `load` pulse, 4 edges after apply.
  - `D`=9 with the strobe and held afterwards.
- Sequence 10'b0000000001 then 10'b0000001000, each held 10 cycles with 1-cycle zero gaps → `load` with `D`=0, then `load` with `D`=3.
- Invalid 10'b1000010000 held 10 cycles → no `load`, `D` unchanged. A following valid key after release is accepted normally.
- Bounce: key asserted for 2 cycles, released, then re-asserted for 10 cycles → only one `load`, after the stable run.
- `enable`=1 for 200 cycles with key 5 pressed:
  - `load` stays 0.
  - `pgt_1hz` rises on the first enabled edge and again 100 cycles later, with 50 high / 50 low.
  - `enable`=0 forces `pgt_1hz`=0 on the next edge.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared microwave-controller definitions: keypad width, BCD width and the
// one-hot to BCD encoder also used by the display decoder.
package encoder_pkg;
  localparam int KEYS  = 10;
  localparam int BCD_W = 4;

  typedef logic [KEYS-1:0]  keys_t;
  typedef logic [BCD_W-1:0] bcd_t;

  // Index of the set bit; callers only pass one-hot values.
  function automatic bcd_t onehot_to_bcd(input keys_t k);
    bcd_t code;
    code = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (k[i]) code = BCD_W'(i);
    end
    return code;
  endfunction
endpackage

// File: rtl/encoder_if.sv
// Keypad/time-entry bus between the controller front panel and the encoder.
interface encoder_if;
  import encoder_pkg::*;

  keys_t keypad;
  logic  enable;
  bcd_t  D;
  logic  load;
  logic  pgt_1hz;

  modport master (output keypad, output enable, input D, input load, input pgt_1hz);
  modport slave  (input keypad, input enable, output D, output load, output pgt_1hz);
endinterface

// File: rtl/encoder_pulse_1hz_gen.sv
// Countdown tick generator: square wave of period CLK_HZ cycles while enabled,
// high for the first half; phase restarts on every enable.
module pulse_1hz_gen #(
  parameter int CLK_HZ = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic pgt_o
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pgt_q, pgt_d;

  always_comb begin
    cnt_d = '0;
    pgt_d = 1'b0;
    if (enable_i) begin
      pgt_d = (cnt_q < HALF);
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      pgt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pgt_q <= pgt_d;
    end
  end

  assign pgt_o = pgt_q;
endmodule

// File: rtl/encoder.sv
// Microwave keypad front end: registers and debounces the one-hot keypad,
// emits one BCD digit + load strobe per press, and runs the 1 Hz tick when enabled.
module encoder
  import encoder_pkg::*;
#(
  parameter int CLK_HZ          = 100,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input logic      clk,
  input logic      reset,
  encoder_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

  keys_t         kp_q, kp_prev_q;
  logic [DW-1:0] db_q, db_d;
  logic          armed_q, armed_d;
  logic          sampled_q;
  logic          seen_idle_q, seen_idle_d;
  bcd_t          d_q, d_d;
  logic          load_q, load_d;
  logic          kp_idle, kp_valid, accept;

  always_comb begin
    kp_idle  = (kp_q == '0);
    kp_valid = $onehot(kp_q);

    // Saturating run length of identical valid samples.
    db_d = '0;
    if (kp_valid) begin
      if (kp_q != kp_prev_q)   db_d = DW'(1);
      else if (db_q != DB_MAX) db_d = db_q + DW'(1);
      else                     db_d = db_q;
    end

    // seen_idle_q blocks a key held through reset until it has been released.
    accept = (db_d == DB_MAX) && armed_q && seen_idle_q && !bus.enable;

    armed_d = armed_q;
    if (accept)       armed_d = 1'b0;
    else if (kp_idle) armed_d = 1'b1;

    seen_idle_d = seen_idle_q | (sampled_q & kp_idle);
    d_d         = accept ? onehot_to_bcd(kp_q) : d_q;
    load_d      = accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kp_q        <= '0;
      kp_prev_q   <= '0;
      db_q        <= '0;
      armed_q     <= 1'b1;
      sampled_q   <= 1'b0;
      seen_idle_q <= 1'b0;
      d_q         <= '0;
      load_q      <= 1'b0;
    end else begin
      kp_q        <= bus.keypad;
      kp_prev_q   <= kp_q;
      db_q        <= db_d;
      armed_q     <= armed_d;
      sampled_q   <= 1'b1;
      seen_idle_q <= seen_idle_d;
      d_q         <= d_d;
      load_q      <= load_d;
    end
  end

  assign bus.D    = d_q;
  assign bus.load = load_q;

  pulse_1hz_gen #(.CLK_HZ(CLK_HZ)) u_div (
    .clk      (clk),
    .reset    (reset),
    .enable_i (bus.enable),
    .pgt_o    (bus.pgt_1hz)
  );
endmodule

// File: tb/tb_encoder.sv
// Directed bench for the microwave keypad encoder: key acceptance, rejection
// of invalid and bouncing input, enable lockout and the 1 Hz tick.
module tb_encoder;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  encoder_if bus ();

  encoder #(.CLK_HZ(100), .DEBOUNCE_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold key k for 'hold' cycles, expect load on cycle load_at (0 = never), then release.
  task automatic press(input keys_t k, input int hold, input int load_at,
                       input bcd_t d_old, input bcd_t d_new, input string tag);
    bus.keypad = k;
    for (int i = 1; i <= hold; i++) begin
      tick;
      chk({tag, "_load"}, bus.load, (i == load_at));
      chk({tag, "_D"}, bus.D, (load_at != 0 && i >= load_at) ? d_new : d_old);
      chk({tag, "_pgt"}, bus.pgt_1hz, 0);
    end
    bus.keypad = '0;
    tick;
    chk({tag, "_rel_load"}, bus.load, 0);
  endtask

  initial begin
    reset      = 1'b1;
    bus.keypad = '0;
    bus.enable = 1'b0;
    tick;
    tick;
    chk("rst_D", bus.D, 0);
    chk("rst_load", bus.load, 0);
    chk("rst_pgt", bus.pgt_1hz, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick;
      chk("idle_D", bus.D, 0);
      chk("idle_load", bus.load, 0);
      chk("idle_pgt", bus.pgt_1hz, 0);
    end

    press(10'b1000000000, 10, 4, 4'd0, 4'd9, "key9");
    press(10'b0000000001, 10, 4, 4'd9, 4'd0, "key0");
    press(10'b0000001000, 10, 4, 4'd0, 4'd3, "key3");
    press(10'b1000010000, 10, 0, 4'd3, 4'd3, "invalid");
    press(10'b0010000000, 10, 4, 4'd3, 4'd7, "key7");

    // Two-cycle bounce, gap, then a stable press.
    bus.keypad = 10'b0000000100;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("bounce_load", bus.load, 0);
      chk("bounce_D", bus.D, 7);
    end
    bus.keypad = '0;
    tick;
    chk("bounce_gap_load", bus.load, 0);
    press(10'b0000000100, 10, 4, 4'd7, 4'd2, "key2");

    // Oven running with key 5 held: no load, 50/50 tick of period 100.
    bus.keypad = 10'b0000100000;
    bus.enable = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick;
      chk("en_pgt", bus.pgt_1hz, (((i - 1) % 100) < 50));
      chk("en_load", bus.load, 0);
      chk("en_D", bus.D, 2);
    end
    bus.keypad = '0;
    tick;
    chk("en_rel_pgt", bus.pgt_1hz, 1);
    chk("en_rel_load", bus.load, 0);
    bus.enable = 1'b0;
    tick;
    chk("dis_pgt", bus.pgt_1hz, 0);
    chk("dis_load", bus.load, 0);
    tick;
    chk("dis_pgt2", bus.pgt_1hz, 0);
    bus.enable = 1'b1;
    tick;
    chk("reen_pgt", bus.pgt_1hz, 1);
    bus.enable = 1'b0;
    tick;
    chk("reen_off_pgt", bus.pgt_1hz, 0);

    // Reset during a press: the held key must be released before acceptance.
    bus.keypad = 10'b0000010000;
    tick;
    tick;
    chk("midrst_pre_load", bus.load, 0);
    reset = 1'b1;
    tick;
    chk("midrst_D", bus.D, 0);
    chk("midrst_load", bus.load, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("midrst_hold_load", bus.load, 0);
      chk("midrst_hold_D", bus.D, 0);
    end
    bus.keypad = '0;
    tick;
    press(10'b0000010000, 10, 4, 4'd0, 4'd4, "key4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
